// File: rtl/pht_access_scheduler.sv
// pht_access_scheduler: arbitrates single-port access to a table of 2-bit
// saturating branch counters between the fetch-side predictor and a small
// FIFO of resolved-branch updates. After reset the table is filled with
// "strongly taken" (2'b11), one entry per cycle.
// Optional feature: define PHT_GSHARE_EN to XOR a global history register
// into both the predict and the update index.
module pht_access_scheduler #(
  parameter int PC_W       = 32,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            request,
  input  logic [PC_W-1:0] req_pc,
  output logic            req_ready,
  output logic            pred_valid,
  output logic            prediction,
  input  logic            result,
  input  logic [PC_W-1:0] res_pc,
  input  logic            taken,
  output logic            res_ready,
  output logic            busy
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   init_ptr_reg;
  logic [1:0]         pht [ENTRIES];
  logic [IDX_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic               fifo_full, fifo_empty;
  logic               push, accept, pop;
  logic [IDX_W-1:0]   req_idx, res_idx, head_idx;
  logic               head_taken;
  logic [1:0]         head_cnt, cnt_next;

  // Only the word-index bits of the PCs select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0],
                            res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

`ifdef PHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_reg;
  assign req_idx = req_pc[IDX_W+1:2] ^ ghr_reg;
  assign res_idx = res_pc[IDX_W+1:2] ^ ghr_reg;

  // Global history shifts in each accepted outcome; it cannot move in INIT
  // because nothing is accepted there.
  always_ff @(posedge clk) begin
    if (rst)       ghr_reg <= '0;
    else if (push) ghr_reg <= {ghr_reg[IDX_W-2:0], taken};
  end
`else
  assign req_idx = req_pc[IDX_W+1:2];
  assign res_idx = res_pc[IDX_W+1:2];
`endif

  assign fifo_full  = (wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}};
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);

  // A predict beats a drain unless the FIFO is full (then req_ready is low).
  assign push   = res_ready && result;
  assign accept = req_ready && request;
  assign pop    = (state_reg == RUN) && !accept && !fifo_empty;

  assign head_idx   = fifo_mem[rd_ptr_reg[AW-1:0]][IDX_W:1];
  assign head_taken = fifo_mem[rd_ptr_reg[AW-1:0]][0];
  assign head_cnt   = pht[head_idx];

  // Saturating increment/decrement of the counter at the FIFO head.
  always_comb begin
    cnt_next = head_cnt;
    if (head_taken && head_cnt != 2'b11)       cnt_next = head_cnt + 2'd1;
    else if (!head_taken && head_cnt != 2'b00) cnt_next = head_cnt - 2'd1;
  end

  // State and initialisation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= INIT;
      init_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == INIT) init_ptr_reg <= init_ptr_reg + 1'b1;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    req_ready  = 1'b0;
    res_ready  = 1'b0;
    case (state_reg)
      INIT: begin
        busy = 1'b1;
        if (init_ptr_reg == {IDX_W{1'b1}}) state_next = RUN;
      end
      RUN: begin
        req_ready = !fifo_full;
        res_ready = !fifo_full;
      end
      default: state_next = INIT;
    endcase
  end

  // Single table port: init fill, or the read-modify-write of a drained update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == INIT) pht[init_ptr_reg] <= 2'b11;
      else if (pop)          pht[head_idx]     <= cnt_next;
    end
  end

  // Registered predict read; prediction holds when no predict was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      prediction <= 1'b0;
    end else begin
      pred_valid <= accept;
      if (accept) prediction <= pht[req_idx][1];
    end
  end

  // Update FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {res_idx, taken};
  end

  // Update FIFO pointers; reset flushes any pending updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pht_access_scheduler.sv
// Testbench for pht_access_scheduler: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_pht_access_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, request, result, taken;
  logic [31:0] req_pc, res_pc;
  logic        req_ready, pred_valid, prediction, res_ready, busy;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int       cnt [16];
  logic [4:0] q [$];
  logic [3:0] ghr;
  logic     exp_valid, exp_pred;

  pht_access_scheduler #(.PC_W(32), .IDX_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .request(request), .req_pc(req_pc),
    .req_ready(req_ready), .pred_valid(pred_valid), .prediction(prediction),
    .result(result), .res_pc(res_pc), .taken(taken), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_idx(input logic [31:0] pc);
`ifdef PHT_GSHARE_EN
    return pc[5:2] ^ ghr;
`else
    return pc[5:2];
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) cnt[i] = 3;
    ghr       = '0;
    exp_valid = 1'b0;
    exp_pred  = 1'b0;
  endtask

  // Count edges until busy falls; INIT must last exactly 16 cycles.
  task automatic wait_init(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, 16);
  endtask

  // One RUN-state cycle with model prediction and checks.
  task automatic step(input logic rq, input logic [31:0] rp,
                      input logic rs, input logic [31:0] sp, input logic tk);
    logic full, acc_req, acc_res, had_head;
    logic [3:0] pidx, sidx;
    logic [4:0] head;
    request = rq; req_pc = rp; result = rs; res_pc = sp; taken = tk;
    full    = (q.size() == DEPTH);
    chk("busy_run", busy, 0);
    chk("req_ready", req_ready, !full);
    chk("res_ready", res_ready, !full);
    acc_req  = rq && !full;
    acc_res  = rs && !full;
    pidx     = model_idx(rp);
    sidx     = model_idx(sp);
    had_head = (q.size() > 0);
    tick();
    exp_valid = acc_req;
    if (acc_req) exp_pred = (cnt[pidx] >= 2);
    if (!acc_req && had_head) begin
      head = q.pop_front();
      if (head[0]) cnt[head[4:1]] = (cnt[head[4:1]] == 3) ? 3 : cnt[head[4:1]] + 1;
      else         cnt[head[4:1]] = (cnt[head[4:1]] == 0) ? 0 : cnt[head[4:1]] - 1;
    end
    if (acc_res) begin
      q.push_back({sidx, tk});
      ghr = {ghr[2:0], tk};
    end
    chk("pred_valid", pred_valid, exp_valid);
    chk("prediction", prediction, exp_pred);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; request = 0; result = 0; taken = 0; req_pc = 0; res_pc = 0;
    model_reset();

    // Reset sequence.
    tick(); tick();
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_prediction", prediction, 0);
    rst = 1'b0;
    wait_init("init_len");
    step(1, 32'h40, 0, 0, 0);
    chk("first_pred", {pred_valid, prediction}, 2'b11);

    // Saturation down: four not-taken updates, then predict.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h40, 0);
    drain();
    step(1, 32'h40, 0, 0, 0);

    // Saturation up, predicting after each increment.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 32'h40, 1);
      drain();
      step(1, 32'h40, 0, 0, 0);
    end

    // Request held: updates accumulate until the FIFO fills, then drain wins.
    for (int i = 0; i < 7; i++)
      step(1, 32'h40 + 4 * i, (i < 5), 32'h44 + 8 * (i % 3), i[0]);
    drain();
    for (int i = 0; i < 4; i++) step(1, 32'h44 + 8 * i, 0, 0, 0);

    // Two queued, then simultaneous push and pop; oldest applied first.
    step(1, 32'h50, 1, 32'h48, 0);
    step(1, 32'h50, 1, 32'h48, 0);
    step(0, 0, 1, 32'h48, 1);
    step(1, 32'h48, 0, 0, 0);
    drain();
    step(1, 32'h48, 0, 0, 0);

    // Mid-run reset with three updates pending.
    for (int i = 0; i < 3; i++) step(1, 32'h60, 1, 32'h60 + 4 * i, 0);
    request = 0; result = 0; rst = 1'b1;
    tick();
    model_reset();
    chk("mid_rst_pred_valid", pred_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_req_ready", req_ready, 0);
    rst = 1'b0;
    wait_init("reinit_len");
    for (int i = 0; i < 16; i++) step(1, 32'h100 + 4 * i, 0, 0, 0);
    step(0, 0, 1, 32'h60, 0);
    drain();
    step(1, 32'h60, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom, $urandom_range(0, 1) == 1);
    drain();
    for (int i = 0; i < 16; i++) step(1, 4 * i, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
